// File: rtl/reg_file_v2.sv
// Parametrised architectural register file with a post-reset clearing
// sweep, a write-to-read bypass and a per-register busy scoreboard.
module reg_file_v2 #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [XLEN-1:0]  mem [NREGS];

  logic run;
  logic wq;
  logic aq;
  logic byp1;
  logic byp2;

  assign run   = (state == RUN);
  assign ready = run;

  assign wq = run && WE3 && !(ZERO_REG && (A3 == '0));
  assign aq = run && alloc_en && !(ZERO_REG && (alloc_addr == '0));

  assign byp1 = BYPASS && WE3 && (A3 == A1);
  assign byp2 = BYPASS && WE3 && (A3 == A2);

  // Alloc is applied after the clear so a new producer wins a tie.
  always_comb begin
    busy_nxt = busy;
    if (wq)
      busy_nxt[A3] = 1'b0;
    if (aq)
      busy_nxt[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREGS - 1))
            state <= RUN;
        end
        RUN: busy <= busy_nxt;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it before reads are ungated.
  always_ff @(posedge clk) begin
    if (!run)
      mem[cnt] <= '0;
    else if (wq)
      mem[A3] <= WD3;
  end

  always_comb begin
    RD1 = '0;
    if (run && !(ZERO_REG && (A1 == '0)))
      RD1 = byp1 ? WD3 : mem[A1];
  end

  always_comb begin
    RD2 = '0;
    if (run && !(ZERO_REG && (A2 == '0)))
      RD2 = byp2 ? WD3 : mem[A2];
  end

  assign busy1 = run && busy[A1] && !byp1;
  assign busy2 = run && busy[A2] && !byp2;

endmodule

// File: tb/tb_reg_file_v2.sv
// Scoreboard bench for reg_file_v2; a bypassing and a
// non-bypassing instance share one stimulus stream.
module tb_reg_file_v2;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_B1  = 2;
  localparam int S_B2  = 3;
  localparam int S_RDY = 4;
  localparam int S_NRD1 = 5;
  localparam int S_NB1  = 6;
  localparam int S_NRDY = 7;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   A1, A2, A3, alloc_addr;
  logic            WE3, alloc_en;
  logic [XLEN-1:0] WD3;

  logic [XLEN-1:0] rd1, rd2, n_rd1, n_rd2;
  logic            busy1, busy2, ready;
  logic            n_busy1, n_busy2, n_ready;

  reg_file_v2 dut (
    .clk(clk), .reset(reset),
    .A1(A1), .A2(A2), .RD1(rd1), .RD2(rd2),
    .A3(A3), .WE3(WE3), .WD3(WD3),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  reg_file_v2 #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset),
    .A1(A1), .A2(A2), .RD1(n_rd1), .RD2(n_rd2),
    .A3(A3), .WE3(WE3), .WD3(WD3),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(n_busy1), .busy2(n_busy2), .ready(n_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_RD1:  return rd1;
      S_RD2:  return rd2;
      S_B1:   return {31'b0, busy1};
      S_B2:   return {31'b0, busy2};
      S_RDY:  return {31'b0, ready};
      S_NRD1: return n_rd1;
      S_NB1:  return {31'b0, n_busy1};
      S_NRDY: return {31'b0, n_ready};
      default: return 'x;
    endcase
  endfunction

  task automatic want(input int s, input string tag,
                      input logic [31:0] v);
    exp_t e;
    e.sel = s;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0;
    alloc_en = 1'b0;
  endtask

  // ready must stay low for n-1 edges and rise on the n-th.
  task automatic sweep(input string tag);
    for (int k = 1; k <= NREGS; k++) begin
      tick();
      want(S_RDY, tag, (k == NREGS) ? 32'd1 : 32'd0);
      want(S_NRDY, tag, (k == NREGS) ? 32'd1 : 32'd0);
      drain();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    want(S_RDY, "rst_rdy", 0);
    want(S_RD1, "rst_rd1", 0);
    want(S_B1, "rst_b1", 0);
    want(S_B2, "rst_b2", 0);
    drain();
    tick();
    tick();
    reset = 1'b0;
    want(S_RDY, "rel_rdy", 0);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; alloc_addr = '0;
    WE3 = 1'b0; alloc_en = 1'b0; WD3 = '0;

    // power-on sweep
    #2;
    pulse_reset();
    sweep("sweep");
    for (int a = 0; a < NREGS; a++) begin
      A1 = AW'(a);
      A2 = AW'(NREGS - 1 - a);
      want(S_RD1, "clr_rd1", 0);
      want(S_RD2, "clr_rd2", 0);
      drain();
    end

    // bypass write/read
    A1 = 5; A3 = 5; WE3 = 1'b1; WD3 = 32'hDEADBEEF;
    want(S_RD1, "byp_rd1", 32'hDEADBEEF);
    want(S_NRD1, "nb_old", 0);
    drain();
    tick();
    idle();
    want(S_RD1, "hold_rd1", 32'hDEADBEEF);
    want(S_NRD1, "nb_hold", 32'hDEADBEEF);
    drain();

    // zero register
    A3 = 0; WE3 = 1'b1; WD3 = 32'h1234;
    alloc_en = 1'b1; alloc_addr = 0; A2 = 0;
    want(S_RD2, "z_rd2", 0);
    want(S_B2, "z_b2", 0);
    drain();
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      want(S_RD2, "z_rd2_n", 0);
      want(S_B2, "z_b2_n", 0);
      drain();
      tick();
    end

    // scoreboard
    A1 = 9; alloc_en = 1'b1; alloc_addr = 9;
    want(S_B1, "sb_pre", 0);
    drain();
    tick();
    idle();
    want(S_B1, "sb_set", 1);
    want(S_NB1, "nb_set", 1);
    drain();
    A3 = 9; WE3 = 1'b1; WD3 = 32'hF4;
    want(S_B1, "sb_byp", 0);
    want(S_RD1, "sb_rd1", 32'hF4);
    want(S_NB1, "nb_wait", 1);
    want(S_NRD1, "nb_rd1", 0);
    drain();
    tick();
    idle();
    want(S_B1, "sb_clr", 0);
    want(S_NB1, "nb_clr", 0);
    want(S_NRD1, "nb_rd1_n", 32'hF4);
    drain();
    alloc_en = 1'b1; alloc_addr = 9;
    A3 = 9; WE3 = 1'b1; WD3 = 32'hF5;
    tick();
    idle();
    want(S_B1, "sb_tie", 1);
    want(S_NB1, "nb_tie", 1);
    want(S_RD1, "tie_rd1", 32'hF5);
    drain();

    // reset mid-sweep
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      want(S_RDY, "mid_rdy", 0);
      drain();
    end
    pulse_reset();
    sweep("resweep");
    A1 = 9;
    want(S_RD1, "rs_rd9", 0);
    want(S_B1, "rs_b9", 0);
    drain();

    // reset mid-RUN
    A3 = 3; WE3 = 1'b1; WD3 = 32'hC;
    tick();
    A3 = 6; WD3 = 32'hA;
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 6;
    tick();
    idle();
    A1 = 3; A2 = 6;
    want(S_RD1, "run_r3", 32'hC);
    want(S_RD2, "run_r6", 32'hA);
    want(S_B2, "run_b6", 1);
    drain();
    pulse_reset();
    sweep("runsweep");
    want(S_RD1, "post_r3", 0);
    want(S_RD2, "post_r6", 0);
    want(S_B2, "post_b6", 0);
    drain();

    // same-cycle write without bypass returns the old value
    A1 = 3; A3 = 3; WE3 = 1'b1; WD3 = 32'h55;
    want(S_NRD1, "nb_same", 0);
    want(S_RD1, "by_same", 32'h55);
    drain();
    tick();
    idle();
    want(S_NRD1, "nb_next", 32'h55);
    want(S_RD1, "by_next", 32'h55);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_v2.md
# reg_file_v2

Parametrised successor to the single-cycle register file in the RISC-V datapath. It provides a width- and depth-configurable architectural register file with a hardwired zero register and write-to-read bypass. It adds a post-reset clearing sweep that zeroes storage one entry per cycle, and a per-register busy scoreboard that the hazard unit uses for load-use and multi-cycle stalls. It sits between decode (A1/A2 reads, alloc) and writeback (A3/WD3).

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers; power of two, ≥ 2.
- AW, $clog2(NREGS): address width (derived).
- ZERO_REG, 1: 1 = register 0 reads 0, is never written and is never busy; 0 = register 0 is ordinary.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = reads return array contents only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  XLEN  read data, port 1; combinational.
- RD2  out  XLEN  read data, port 2; combinational.
- A3  in  AW  write address.
- WE3  in  1  write enable.
- WD3  in  XLEN  write data.
- alloc_en  in  1  mark alloc_addr busy; an in-flight producer has been issued.
- alloc_addr  in  AW  register to mark busy.
- busy1  out  1  A1 has a pending producer that is not satisfied this cycle.
- busy2  out  1  A2 has a pending producer that is not satisfied this cycle.
- ready  out  1  high in RUN; low during reset and CLEAR.

## Operation
- States are CLEAR and RUN.
  - Asserting reset forces CLEAR immediately: sweep counter `cnt` = 0, all busy bits = 0.
  - The array is not reset asynchronously.
- CLEAR:
  - Each rising edge with reset low writes 0 to mem[cnt] and increments cnt.
  - The edge that writes mem[NREGS-1] moves the block to RUN.
  - WE3 and alloc_en are ignored.
  - RD1, RD2, busy1 and busy2 are held at 0; ready = 0.
- RUN:
  - ready = 1.
  - Writes: if WE3 is high (and A3 ≠ 0 when ZERO_REG = 1), mem[A3] ← WD3 on the edge.
  - Reads:
    - RDn = 0 if ZERO_REG and An = 0.
    - Otherwise RDn = WD3 if BYPASS, WE3 is high and A3 = An.
    - Otherwise RDn = mem[An].
  - Scoreboard updates on each edge:
    - A qualifying write clears busy[A3].
    - alloc_en sets busy[alloc_addr].
    - Same edge, same address: set wins, because the new producer supersedes the old.
    - When ZERO_REG = 1, busy[0] is never set.
  - busyn = busy[An] & ~(BYPASS & WE3 & A3 = An).
    - A write landing this cycle satisfies the reader when bypass is enabled.
    - With BYPASS = 0, busyn stays high until the cycle after the write.
- A read and a write to the same address in the same cycle with BYPASS = 0 returns the old value.

## Timing
- Read latency is 0 cycles (combinational). Write is visible through the array on the cycle after the edge, and same-cycle when BYPASS = 1.
- ready rises exactly NREGS rising edges after reset deasserts. No edge with reset high counts.
- Reset asserted mid-CLEAR or mid-RUN:
  - ready drops, cnt is zeroed and busy is cleared, all asynchronously.
  - The sweep restarts from 0 after deassertion.
  - Array contents are undefined until the sweep completes, and are never exposed because reads are gated during CLEAR.
- Alloc-to-busy latency is 1 edge: busyn reflects an alloc on the cycle after alloc_en.
- Outputs while reset is high: ready = 0, RD1 = RD2 = 0, busy1 = busy2 = 0.

## Test plan
- Reset sweep, NREGS = 32:
  - Pulse reset, then release it; ready must be 0 for 32 edges and 1 after the 32nd.
  - In RUN, reading A1 = 0..31 must return 0 for every address.
- Write/read, bypass:
  - In RUN, set WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF with A1 = 5; RD1 must be 0xDEADBEEF in the same cycle.
  - With WE3 = 0 on the next cycle, RD1 must still be 0xDEADBEEF.
- Zero register:
  - Write A3 = 0, WD3 = 0x1234 with alloc_addr = 0 and alloc_en = 1.
  - Reading A2 = 0 must give RD2 = 0 and busy2 = 0 on all following cycles.
- Scoreboard:
  - alloc_en with alloc_addr = 9; the next cycle, with A1 = 9, busy1 must be 1.
  - Write A3 = 9, WD3 = 0xF4 that cycle; busy1 must be 0 and RD1 = 0xF4.
  - Repeat the alloc and the write on the same edge to register 9; busy must remain 1.
- Reset mid-sweep:
  - Assert reset after 10 CLEAR edges; ready must stay 0.
  - After release, ready must rise only after a full 32 further edges.
- Reset mid-RUN, then BYPASS = 0:
  - Set registers 3 = 0xC and 6 = 0xA and allocate register 6; then reset.
  - After the sweep, register 3 must read 0 and busy2 with A2 = 6 must read 0.
  - Rebuild with BYPASS = 0: a same-cycle write to 3 of 0x55 with A1 = 3 must read the old value 0, then 0x55 on the next cycle.
